// File: rtl/aes_dec_ark_stage.sv
// AES-128 decryption AddRoundKey stage.
// Holds the NROUNDS+1 round keys and XORs each accepted state word with the
// key chosen by its round index. Results, together with routing flags for the
// inverse MixColumns block, leave through a 2-entry FIFO with valid/ready
// handshakes on both sides.
module aes_dec_ark_stage #(
  parameter int NROUNDS = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         key_wr,
  input  logic [3:0]   key_addr,
  input  logic [0:127] key_data,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [0:127] in_data,
  input  logic [3:0]   in_round,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [0:127] out_data,
  output logic [3:0]   out_round,
  output logic         out_mix,
  output logic         out_last,
  output logic         out_err
);

  // One buffered result: data plus everything that travels with it.
  typedef struct packed {
    logic [0:127] data;
    logic [3:0]   round;
    logic         mix;
    logic         last;
    logic         err;
  } entry_t;

  // Key store: plain registers so the accept cycle can read combinationally.
  logic [0:127] key_q [0:NROUNDS];

  // Output FIFO state. head_q points at the oldest entry.
  entry_t       buf_q [0:1];
  entry_t       buf_d [0:1];
  logic         head_q, head_d;
  logic [1:0]   count_q, count_d;

  // Handshake qualifiers.
  logic         push, pop;
  logic         wr_idx;

  // Freshly computed entry for the word being offered.
  logic [0:127] key_sel;
  logic         round_err;
  entry_t       new_entry;

  // in_ready depends only on the registered occupancy, never on out_ready.
  assign in_ready  = (count_q < 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Head entry drives the outputs; entries are zeroed on reset so the
  // outputs show zero until the first word arrives.
  assign out_data  = buf_q[head_q].data;
  assign out_round = buf_q[head_q].round;
  assign out_mix   = buf_q[head_q].mix;
  assign out_last  = buf_q[head_q].last;
  assign out_err   = buf_q[head_q].err;

  // Select the round key; out-of-range rounds see an all-zero key.
  always_comb begin
    key_sel   = '0;
    round_err = (int'(in_round) > NROUNDS);
    for (int i = 0; i <= NROUNDS; i++) begin
      if (in_round == 4'(i)) begin
        key_sel = key_q[i];
      end
    end
  end

  // Build the result word and its routing flags.
  always_comb begin
    new_entry.data  = in_data ^ key_sel;
    new_entry.round = in_round;
    new_entry.mix   = (in_round != 4'd0) && (int'(in_round) <= NROUNDS - 1);
    new_entry.last  = (in_round == 4'd0);
    new_entry.err   = round_err;
  end

  // FIFO next-state: write slot is head when empty, the other slot otherwise.
  always_comb begin
    buf_d[0] = buf_q[0];
    buf_d[1] = buf_q[1];
    head_d   = head_q;
    count_d  = count_q;
    wr_idx   = head_q ^ (count_q == 2'd1);
    if (push) begin
      buf_d[wr_idx] = new_entry;
    end
    if (pop) begin
      head_d = ~head_q;
    end
    count_d = count_q + {1'b0, push} - {1'b0, pop};
  end

  // Key store update; indices above NROUNDS match no entry and are dropped.
  // A write in the accept cycle lands after the read, so the word sees the old key.
  always_ff @(posedge clk) begin
    for (int i = 0; i <= NROUNDS; i++) begin
      if (rst) begin
        key_q[i] <= '0;
      end else if (key_wr && (key_addr == 4'(i))) begin
        key_q[i] <= key_data;
      end
    end
  end

  // FIFO registers; reset discards in-flight words and blocks that edge's accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      buf_q[0] <= '0;
      buf_q[1] <= '0;
      head_q   <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      buf_q[0] <= buf_d[0];
      buf_q[1] <= buf_d[1];
      head_q   <= head_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: doc/aes_dec_ark_stage.md
# aes_dec_ark_stage

Registered AddRoundKey stage for the AES-128 decryption datapath, placed directly upstream of the inverse MixColumns block. It holds the 11 round keys in a local key store, XORs each incoming 128-bit state with the key selected by its round index, and hands the result downstream through a 2-entry output buffer with valid/ready handshakes. Sideband flags tell the consumer whether the result must pass through inverse MixColumns (rounds 9..1) or bypass it (round 10 initial key add, round 0 final output).

## Interface
Parameters:
- NROUNDS, 10, number of AES rounds; the key store holds NROUNDS+1 entries, indices 0..NROUNDS.

Ports:
- clk  input  1  rising-edge clock; single clock domain.
- rst  input  1  reset, synchronous, active-high.
- key_wr  input  1  write strobe for the key store.
- key_addr  input  4  key index to write; values > NROUNDS are ignored.
- key_data  input  [0:127]  round key; bits [0:7] are byte 0, column-major byte order.
- in_valid  input  1  upstream state word valid.
- in_ready  output  1  stage can accept a word this cycle.
- in_data  input  [0:127]  state word, same byte order as key_data.
- in_round  input  4  index of the key to apply.
- out_valid  output  1  out_data and the flags are valid.
- out_ready  input  1  downstream accepts this cycle.
- out_data  output  [0:127]  in_data XOR key[in_round].
- out_round  output  4  round index carried with the word.
- out_mix  output  1  1 when 1 <= round <= NROUNDS-1, meaning route through inverse MixColumns.
- out_last  output  1  1 when round == 0, meaning the word is final plaintext.
- out_err  output  1  1 when round > NROUNDS; the XOR uses an all-zero key.

## Operation
- Key store: NROUNDS+1 registers of 128 bits. A key_wr with a valid key_addr updates the entry at the clock edge.
- Accept: a word is accepted when in_valid && in_ready. At that edge the stage computes {in_data ^ key[in_round], in_round, mix, last, err} and pushes the result into the output buffer.
- Key read timing: the key is read combinationally in the accept cycle. If key_wr targets the same index in that cycle, the old key is used.
- Output buffer: 2-entry FIFO with occupancy count 0..2. The head entry drives out_*. A pop happens on out_valid && out_ready.
- in_ready = (count < 2). It is derived from the registered count only; there is no combinational path from out_ready to in_ready.
- Count update:
  - push only: +1.
  - pop only: −1.
  - push and pop together: unchanged, head advances.
- Order is strictly FIFO. Flags travel with their data.
- out_err words are still delivered downstream; they are not dropped.
- Reset effects:
  - clears count to 0 and all buffer entries.
  - clears all key-store entries to 0.
  - any in-flight words are lost.

## Timing
- Reset values:
  - in_ready = 1.
  - out_valid = 0.
  - out_data = 0, out_round = 0.
  - out_mix = 0, out_last = 0, out_err = 0.
- Latency: a word accepted at edge N appears on out_* at N+1 if the buffer was empty; otherwise it appears after the entries ahead of it are popped.
- Throughput: 1 word per cycle when out_ready is held high.
- Stall: out_* hold stable while out_valid && !out_ready.
- Full: after 2 pushes with no pop, in_ready drops to 0 in the next cycle. With count = 2 and out_ready = 1, the pop happens and in_ready returns to 1 in the following cycle.
- rst asserted mid-stream: outputs take their reset values at the next edge, and that edge accepts nothing regardless of in_valid.

## Test plan
- Load key[10] = 13111d7fe3944a17f307a78b4d2b30c5, then send in_data = 69c4e0d86a7b0430d8cdb78070b4c55a with round 10 → out_data = 7ad5fda789ef4e272bca100b3d9ff59f, out_mix = 0, out_last = 0, out_valid one cycle after accept.
- Send 11 back-to-back words with rounds 10..0 and out_ready = 1 → one output per cycle in order; out_mix = 1 only for rounds 9..1; out_last = 1 only for round 0.
- Hold out_ready = 0 and offer 3 words → 2 accepted, in_ready = 0, out_* stable. Release out_ready → words delivered in order with no loss or duplication.
- In the same cycle, key_wr to index 5 and accept a word with round 5 → that word uses the old key; the next round-5 word uses the new key.
- Send round = 12, and separately key_wr with key_addr = 11 → word delivered unchanged with out_err = 1; the key store is not modified.
- Assert rst with count = 2 → out_valid = 0 and in_ready = 1 after the edge, and all keys read back as 0 (a round-3 word passes through unchanged).
